// File: rtl/varint_extract_64.sv
// Protobuf varint extractor: scans a tkeep-qualified 64-bit byte stream one lane per cycle and
// packs each varint MSB-first, paced so the downstream decoder sees at most one word per MIN_GAP cycles.
module varint_extract_64 #(
    parameter int DATA_BITS    = 64,
    parameter int ENCODED_BITS = 64,
    parameter int MIN_GAP      = 4
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_BITS-1:0]    s_axis_tdata,
    input  logic [DATA_BITS/8-1:0]  s_axis_tkeep,
    input  logic                    s_axis_tlast,
    output logic                    m_axis_tvalid,
    output logic [ENCODED_BITS-1:0] m_axis_tdata,
    output logic [3:0]              m_axis_tuser,
    output logic                    err_overflow,
    output logic                    err_trunc
);

    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {
        S_SCAN = 2'd0,
        S_HOLD = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                  state;
    logic                    buf_valid;
    logic [DATA_BITS-1:0]    buf_data;
    logic [DATA_BITS/8-1:0]  buf_keep;
    logic                    buf_last;
    logic [2:0]              ptr;
    logic [ENCODED_BITS-1:0] acc;
    logic [3:0]              cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic                    discard;

    logic                    accept;
    logic                    scan_en;
    logic [2:0]              hi_lane;
    logic [7:0]              lane_byte;
    logic                    lane_keep;
    logic                    release_beat;
    logic                    take;
    logic                    drop;
    logic                    complete;
    logic                    overflow;
    logic                    trunc;
    logic [3:0]              cnt_after;
    logic [2:0]              slot;
    logic [ENCODED_BITS-1:0] acc_wr;
    logic                    buf_valid_n;

    always_comb begin
        hi_lane = 3'd0;
        for (int k = 0; k < DATA_BITS/8; k++) begin
            if (buf_keep[k]) begin
                hi_lane = 3'(k);
            end
        end
    end

    always_comb begin
        accept       = s_axis_tvalid & s_axis_tready;
        scan_en      = buf_valid & (state == S_SCAN);
        lane_byte    = buf_data[{ptr, 3'b000} +: 8];
        lane_keep    = buf_keep[ptr];
        release_beat = scan_en & ((buf_keep == '0) | (ptr == hi_lane));
        take         = scan_en & lane_keep & ~discard;
        drop         = scan_en & lane_keep & discard;
        cnt_after    = cnt + 4'(take);
        complete     = take & ~lane_byte[7];
        overflow     = take & lane_byte[7] & (cnt_after == 4'd8);
        // A tlast release with bytes still collected (including an overflow on that very byte) is a truncation.
        trunc        = release_beat & buf_last & ~complete & (cnt_after != 4'd0);
        slot         = 3'd7 - cnt[2:0];
        acc_wr       = acc;
        acc_wr[{slot, 3'b000} +: 8] = lane_byte;
        if (accept) begin
            buf_valid_n = 1'b1;
        end else if (release_beat) begin
            buf_valid_n = 1'b0;
        end else begin
            buf_valid_n = buf_valid;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= S_SCAN;
            buf_valid     <= 1'b0;
            buf_data      <= '0;
            buf_keep      <= '0;
            buf_last      <= 1'b0;
            ptr           <= 3'd0;
            acc           <= '0;
            cnt           <= 4'd0;
            gap_cnt       <= '0;
            discard       <= 1'b0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 4'd0;
            err_overflow  <= 1'b0;
            err_trunc     <= 1'b0;
        end else begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 4'd0;
            err_overflow  <= overflow;
            err_trunc     <= trunc;
            buf_valid     <= buf_valid_n;
            s_axis_tready <= ~buf_valid_n;

            if (accept) begin
                buf_data <= s_axis_tdata;
                buf_keep <= s_axis_tkeep;
                buf_last <= s_axis_tlast;
            end

            if (release_beat) begin
                ptr <= 3'd0;
            end else if (scan_en) begin
                ptr <= ptr + 1'b1;
            end

            if (release_beat && buf_last) begin
                discard <= 1'b0;
            end else if (overflow) begin
                discard <= 1'b1;
            end else if (drop && !lane_byte[7]) begin
                discard <= 1'b0;
            end

            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            // Entering EMIT registers the word and starts the gap; tvalid is high for the EMIT cycle only.
            case (state)
                S_SCAN: begin
                    if (overflow || trunc) begin
                        acc <= '0;
                        cnt <= 4'd0;
                    end else if (take) begin
                        acc <= acc_wr;
                        cnt <= cnt_after;
                    end
                    if (complete) begin
                        if (gap_cnt == '0) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= acc_wr;
                            m_axis_tuser  <= cnt_after;
                            acc           <= '0;
                            cnt           <= 4'd0;
                            gap_cnt       <= GAP_W'(MIN_GAP - 1);
                            state         <= S_EMIT;
                        end else begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (gap_cnt == '0) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= acc;
                        m_axis_tuser  <= cnt;
                        acc           <= '0;
                        cnt           <= 4'd0;
                        gap_cnt       <= GAP_W'(MIN_GAP - 1);
                        state         <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    state <= S_SCAN;
                end
                default: begin
                    state <= S_SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_varint_extract_64.sv
// Bench for varint_extract_64: directed scenarios plus a randomized byte stream checked against
// a byte-level varint model.
module tb_varint_extract_64;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        m_axis_tvalid;
    logic [63:0] m_axis_tdata;
    logic [3:0]  m_axis_tuser;
    logic        err_overflow;
    logic        err_trunc;

    int checks = 0;
    int failures = 0;

    varint_extract_64 dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .err_overflow  (err_overflow),
        .err_trunc     (err_trunc)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    int          cyc = 0;
    logic [63:0] obs_data[$];
    logic [3:0]  obs_user[$];
    int          obs_cyc[$];
    int          n_ovf = 0;
    int          n_trunc = 0;
    int          gap_viol = 0;
    int          idle_dirty = 0;
    int          last_v = -100;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_axis_tvalid === 1'b1) begin
            obs_data.push_back(m_axis_tdata);
            obs_user.push_back(m_axis_tuser);
            obs_cyc.push_back(cyc);
            if (cyc - last_v < 4) gap_viol = gap_viol + 1;
            last_v = cyc;
        end else if (m_axis_tdata !== 64'd0 || m_axis_tuser !== 4'd0) begin
            idle_dirty = idle_dirty + 1;
        end
        if (err_overflow === 1'b1) n_ovf = n_ovf + 1;
        if (err_trunc === 1'b1) n_trunc = n_trunc + 1;
    end

    logic [63:0] bq_d[$];
    logic [7:0]  bq_k[$];
    logic        bq_l[$];

    task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        bq_d.push_back(d);
        bq_k.push_back(k);
        bq_l.push_back(l);
    endtask

    task automatic send_beats(input int max_idle);
        int t;
        while (bq_d.size() > 0) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = bq_d.pop_front();
            s_axis_tkeep  = bq_k.pop_front();
            s_axis_tlast  = bq_l.pop_front();
            t = 0;
            while (s_axis_tready !== 1'b1 && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (s_axis_tready !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL tready_timeout got=%b want=1", s_axis_tready);
            end
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            if (max_idle > 0) repeat ($urandom_range(0, max_idle)) @(negedge clk);
        end
    endtask

    task automatic wait_outs(input int target);
        int t;
        t = 0;
        while (obs_data.size() < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (12) @(negedge clk);
    endtask

    function automatic logic [63:0] got_d(input int i);
        return (i < obs_data.size()) ? obs_data[i] : 64'hx;
    endfunction

    function automatic logic [3:0] got_u(input int i);
        return (i < obs_user.size()) ? obs_user[i] : 4'hx;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, err_overflow, err_trunc} !== 70'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, err_overflow, err_trunc});
        end
        aresetn = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_tready_after got=%b want=1", s_axis_tready);
        end
    endtask

    task automatic test_single();
        int b, o0, t0;
        b = obs_data.size(); o0 = n_ovf; t0 = n_trunc;
        push_beat(64'h0000_0000_0000_0196, 8'h03, 1'b1);
        send_beats(0);
        wait_outs(b + 1);
        checks++;
        if (obs_data.size() - b !== 1) begin
            failures++;
            $display("FAIL single_count got=%0d want=1", obs_data.size() - b);
        end
        checks++;
        if (got_d(b) !== 64'h9601_0000_0000_0000 || got_u(b) !== 4'd2) begin
            failures++;
            $display("FAIL single_word got=%h/%0d want=9601000000000000/2", got_d(b), got_u(b));
        end
        checks++;
        if (n_ovf - o0 !== 0 || n_trunc - t0 !== 0) begin
            failures++;
            $display("FAIL single_errors got=%0d/%0d want=0/0", n_ovf - o0, n_trunc - t0);
        end
    endtask

    task automatic test_two_in_beat();
        int b;
        b = obs_data.size();
        push_beat(64'h0000_0000_0002_AC05, 8'h07, 1'b1);
        send_beats(0);
        wait_outs(b + 2);
        checks++;
        if (obs_data.size() - b !== 2) begin
            failures++;
            $display("FAIL two_count got=%0d want=2", obs_data.size() - b);
        end
        checks++;
        if (got_d(b) !== 64'h0500_0000_0000_0000 || got_u(b) !== 4'd1) begin
            failures++;
            $display("FAIL two_first got=%h/%0d want=0500000000000000/1", got_d(b), got_u(b));
        end
        checks++;
        if (got_d(b + 1) !== 64'hAC02_0000_0000_0000 || got_u(b + 1) !== 4'd2) begin
            failures++;
            $display("FAIL two_second got=%h/%0d want=ac02000000000000/2", got_d(b + 1), got_u(b + 1));
        end
        checks++;
        if (obs_cyc.size() < b + 2 || obs_cyc[b + 1] - obs_cyc[b] !== 4) begin
            failures++;
            $display("FAIL two_spacing got=%0d want=4",
                     (obs_cyc.size() >= b + 2) ? obs_cyc[b + 1] - obs_cyc[b] : -1);
        end
    endtask

    task automatic test_span();
        int b;
        b = obs_data.size();
        push_beat(64'h8080_0000_0000_0000, 8'hC0, 1'b0);
        push_beat(64'h0000_0000_0000_0001, 8'h01, 1'b1);
        send_beats(1);
        wait_outs(b + 1);
        checks++;
        if (obs_data.size() - b !== 1 || got_d(b) !== 64'h8080_0100_0000_0000 || got_u(b) !== 4'd3) begin
            failures++;
            $display("FAIL span_word got=%h/%0d n=%0d want=8080010000000000/3 n=1",
                     got_d(b), got_u(b), obs_data.size() - b);
        end
    endtask

    task automatic test_overflow();
        int b, o0, t0;
        b = obs_data.size(); o0 = n_ovf; t0 = n_trunc;
        push_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        push_beat(64'h0000_0000_0007_01FF, 8'h07, 1'b1);
        send_beats(0);
        wait_outs(b + 1);
        checks++;
        if (n_ovf - o0 !== 1 || n_trunc - t0 !== 0) begin
            failures++;
            $display("FAIL ovf_errors got=%0d/%0d want=1/0", n_ovf - o0, n_trunc - t0);
        end
        checks++;
        if (obs_data.size() - b !== 1 || got_d(b) !== 64'h0700_0000_0000_0000 || got_u(b) !== 4'd1) begin
            failures++;
            $display("FAIL ovf_word got=%h/%0d n=%0d want=0700000000000000/1 n=1",
                     got_d(b), got_u(b), obs_data.size() - b);
        end
    endtask

    task automatic test_trunc();
        int b, t0;
        b = obs_data.size(); t0 = n_trunc;
        push_beat(64'h0000_0000_0000_0080, 8'h01, 1'b1);
        send_beats(0);
        repeat (12) @(negedge clk);
        checks++;
        if (n_trunc - t0 !== 1 || obs_data.size() - b !== 0) begin
            failures++;
            $display("FAIL trunc_pulse got=%0d/%0d want=1/0", n_trunc - t0, obs_data.size() - b);
        end
        push_beat(64'h0000_0000_0000_002A, 8'h01, 1'b1);
        send_beats(0);
        wait_outs(b + 1);
        checks++;
        if (obs_data.size() - b !== 1 || got_d(b) !== 64'h2A00_0000_0000_0000 || got_u(b) !== 4'd1) begin
            failures++;
            $display("FAIL trunc_next got=%h/%0d n=%0d want=2a00000000000000/1 n=1",
                     got_d(b), got_u(b), obs_data.size() - b);
        end
    endtask

    task automatic test_reset_hold();
        int t, b, o0, t0;
        push_beat(64'h0000_0000_0000_0605, 8'h03, 1'b1);
        send_beats(0);
        t = 0;
        while (m_axis_tvalid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL rh_first_pulse got=%b want=1", m_axis_tvalid);
        end
        repeat (2) @(negedge clk);
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, err_overflow, err_trunc} !== 70'd0) begin
            failures++;
            $display("FAIL rh_async_clear got=%h want=0",
                     {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, err_overflow, err_trunc});
        end
        b = obs_data.size(); o0 = n_ovf; t0 = n_trunc;
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL rh_tready got=%b want=1", s_axis_tready);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (obs_data.size() - b !== 0 || n_ovf - o0 !== 0 || n_trunc - t0 !== 0) begin
            failures++;
            $display("FAIL rh_stale got=%0d/%0d/%0d want=0/0/0", obs_data.size() - b, n_ovf - o0, n_trunc - t0);
        end
    endtask

    task automatic test_random();
        logic [63:0] exp_d[$];
        logic [3:0]  exp_u[$];
        int          e_ovf, e_trunc, b, o0, t0, g0, d0, cnt, nb;
        logic [63:0] acc, d;
        logic [7:0]  k, v;
        bit          disc, ovf_last, last;
        e_ovf = 0; e_trunc = 0; cnt = 0; acc = '0; disc = 0;
        b = obs_data.size(); o0 = n_ovf; t0 = n_trunc; g0 = gap_viol; d0 = idle_dirty;
        for (int p = 0; p < 40; p++) begin
            nb = $urandom_range(1, 4);
            for (int bi = 0; bi < nb; bi++) begin
                k = 8'($urandom_range(1, 255));
                last = (bi == nb - 1);
                for (int l = 0; l < 8; l++) begin
                    v = 8'($urandom_range(0, 127));
                    if (p == 0 || $urandom_range(0, 99) < 65) v[7] = 1'b1;
                    d[8*l +: 8] = v;
                end
                ovf_last = 0;
                for (int l = 0; l < 8; l++) begin
                    if (k[l]) begin
                        v = d[8*l +: 8];
                        ovf_last = 0;
                        if (disc) begin
                            if (!v[7]) disc = 0;
                        end else begin
                            acc[63 - 8*cnt -: 8] = v;
                            cnt++;
                            if (!v[7]) begin
                                exp_d.push_back(acc);
                                exp_u.push_back(4'(cnt));
                                acc = '0;
                                cnt = 0;
                            end else if (cnt == 8) begin
                                e_ovf++;
                                acc = '0;
                                cnt = 0;
                                disc = 1;
                                ovf_last = 1;
                            end
                        end
                    end
                end
                if (last) begin
                    if (cnt != 0 || ovf_last) e_trunc++;
                    acc = '0;
                    cnt = 0;
                    disc = 0;
                end
                push_beat(d, k, last);
            end
        end
        send_beats(2);
        wait_outs(b + exp_d.size());
        checks++;
        if (obs_data.size() - b !== exp_d.size()) begin
            failures++;
            $display("FAIL rand_count got=%0d want=%0d", obs_data.size() - b, exp_d.size());
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            checks++;
            if (got_d(b + i) !== exp_d[i] || got_u(b + i) !== exp_u[i]) begin
                failures++;
                $display("FAIL rand_word[%0d] got=%h/%0d want=%h/%0d", i, got_d(b + i), got_u(b + i),
                         exp_d[i], exp_u[i]);
            end
        end
        checks++;
        if (n_ovf - o0 !== e_ovf || n_trunc - t0 !== e_trunc) begin
            failures++;
            $display("FAIL rand_errors got=%0d/%0d want=%0d/%0d", n_ovf - o0, n_trunc - t0, e_ovf, e_trunc);
        end
        checks++;
        if (gap_viol - g0 !== 0 || idle_dirty - d0 !== 0) begin
            failures++;
            $display("FAIL rand_gap_idle got=%0d/%0d want=0/0", gap_viol - g0, idle_dirty - d0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_two_in_beat();
        test_span();
        test_overflow();
        test_trunc();
        test_random();
        test_reset_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
